fp_dot_feeder: RTL and testbench
================================

// Module: fp_dot_feeder
// PURPOSE
// Transmit side of the FP32 dot-product interface. Accepts one command (two base addresses, length, optional bias),
// reads A/B operand pairs from two 1-cycle-latency RAM ports, and streams them one pair per cycle to fp_mul_sum_module.
// Drives in_valid, in_acc_sign, finish and custom_last, then waits for sendable, captures result_all,
// and returns it over a valid/ready result port.
// PARAMETERS
// ADDR_W   10      operand RAM address width
// LEN_W    16      vector length width (pairs)
// LANES    8       pairs per multiplier group; must equal consumer RST_MAX
// TIMEOUT  1024    max cycles waiting for sendable before error
// PORTS
// aclk           in   1       single clock
// aresetn        in   1       async active-low reset
// cmd_valid      in   1       command offered
// cmd_ready      out  1       high only in IDLE
// cmd_base_a     in   ADDR_W  first A address
// cmd_base_b     in   ADDR_W  first B address
// cmd_len        in   LEN_W   number of real pairs (0 = illegal)
// cmd_bias       in   32      FP32 bias added to final sum
// cmd_bias_en    in   1       use cmd_bias
// ram_a_addr     out  ADDR_W  A read address
// ram_b_addr     out  ADDR_W  B read address
// ram_rd_en      out  1       read strobe; data returns next cycle
// ram_a_data     in   32      A word
// ram_b_data     in   32      B word
// in_A/in_B      out  32      operands to dot unit
// in_valid       out  1       pair valid
// in_acc_sign    out  1       accumulate onto previous group
// finish         out  1       last beat of vector
// custom_last    out  32      bias value
// en_custom_last out  1       bias enable, held for whole transaction
// result_all     in   32      dot unit result
// sendable       in   1       result_all valid this cycle
// res_data       out  32      captured result
// res_valid      out  1       result held until res_ready
// res_ready      in   1       result accepted
// busy           out  1       not IDLE
// err            out  1       1-cycle pulse: len==0 reject or sendable timeout
// BEHAVIOUR
// - Reset (async, any state): FSM=IDLE; all outputs 0 except cmd_ready=1; counters cleared; pending result discarded.
// - FSM: IDLE -> ISSUE on cmd_valid&&cmd_len!=0 (handshake latches cmd fields; bias latched into custom_last).
//        cmd_valid&&cmd_len==0 -> err pulse, stay IDLE.
// - ISSUE: ram_rd_en=1 each cycle, addr = base+i, i = 0..len-1. After the last read -> PAD if len%LANES!=0, else DRAIN.
// - Read-data alignment: in_valid/in_A/in_B registered from RAM data one cycle after ram_rd_en, giving a continuous 1 pair/clk stream.
//   Downstream has no backpressure.
// - PAD: emit (LANES - len%LANES) beats of in_A=in_B=32'h0, in_valid=1; total beats = ceil(len/LANES)*LANES.
// - in_acc_sign = 0 on all beats of group 0, 1 on every beat of groups >=1.
// - finish = 1 only on the final beat (real or padded), coincident with in_valid.
// - DRAIN -> WAIT: once the final beat has left. WAIT: timeout counter runs.
//   First sendable=1 captures result_all into res_data, sets res_valid -> OUT.
//   Counter reaching TIMEOUT -> err pulse, IDLE, no result.
// - OUT: res_valid held with res_data stable until res_ready; on handshake -> IDLE (cmd_ready=1 the next cycle).
// - sendable outside WAIT is ignored. Address arithmetic wraps modulo 2^ADDR_W.
// - Latency: cmd handshake to first in_valid = 2 cycles; to finish = 1 + ceil(len/LANES)*LANES cycles.
// STRUCTURE
// - fp_dot_defs.vh: FSM state encodings (IDLE, ISSUE, PAD, DRAIN, WAIT, OUT), FP32 zero constant.
// - One sub-module: fp_dot_beat_gen. It holds the beat/group counters and produces in_acc_sign, finish and pad select
//   from len and LANES. FSM, RAM ports and result capture stay in the top.
// TESTING
// - len=8, A=1.0, B=2.0 -> 8 in_valid beats, no pad, finish on beat 8, in_acc_sign=0 throughout; sendable with 32'h41800000 (16.0) -> res_data=32'h41800000.
// - len=10 -> 16 beats (6 zero pads), in_acc_sign=1 on beats 9-16, finish on beat 16 only.
// - cmd_len=0 -> err pulses 1 cycle, no ram_rd_en, cmd_ready stays 1.
// - sendable never asserted, TIMEOUT=32 -> err pulse 32 cycles after WAIT entry, back to IDLE, res_valid=0.
// - res_ready held low 5 cycles -> res_valid/res_data stable for 5 cycles; new cmd_valid not accepted until handshake.
// - aresetn low mid-ISSUE (beat 3 of 8) -> all outputs 0 immediately; after release a new len=4 command runs cleanly.

Source files
------------

// File: rtl/fp_dot_feeder_pkg.sv
// Shared FSM state encoding and FP32 constants for the dot-product feeder.
package fp_dot_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_PAD,
    S_DRAIN,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_dot_beat_gen.sv
// Request-side beat/group counters: tags each issued beat as pad, accumulate or final
// so the top can pipeline the tags alongside the RAM read data.
module fp_dot_beat_gen #(
  parameter int LEN_W = 16,
  parameter int LANES = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             step,
  input  logic [LEN_W-1:0] len,
  output logic             req_pad,
  output logic             req_acc,
  output logic             req_last,
  output logic             real_last
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);
  localparam logic [LEN_W:0] ONE = 1;

  logic [LEN_W:0]    idx;
  logic [LEN_W:0]    len_ext;
  logic [LEN_W:0]    group;
  logic [LANE_W-1:0] lane;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx     <= '0;
      len_ext <= '0;
      group   <= '0;
      lane    <= '0;
    end else if (start) begin
      idx     <= '0;
      len_ext <= {1'b0, len};
      group   <= '0;
      lane    <= '0;
    end else if (step) begin
      idx <= idx + ONE;
      if (lane == LANE_MAX) begin
        lane  <= '0;
        group <= group + ONE;
      end else begin
        lane <= lane + LANE_W'(1);
      end
    end
  end

  assign req_pad   = (idx >= len_ext);
  assign real_last = ((idx + ONE) == len_ext);
  // The vector ends on the last lane of the group that holds (or follows) the final real pair.
  assign req_last  = (lane == LANE_MAX) && ((idx + ONE) >= len_ext);
  assign req_acc   = (group != '0);

endmodule

// File: rtl/fp_dot_feeder.sv
// Transmit side of the FP32 dot-product interface: fetches A/B pairs, pads to whole
// multiplier groups, streams them one per cycle, then collects and returns the result.
module fp_dot_feeder
  import fp_dot_feeder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 16,
  parameter int LANES   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [31:0]       cmd_bias,
  input  logic              cmd_bias_en,
  output logic [ADDR_W-1:0] ram_a_addr,
  output logic [ADDR_W-1:0] ram_b_addr,
  output logic              ram_rd_en,
  input  logic [31:0]       ram_a_data,
  input  logic [31:0]       ram_b_data,
  output logic [31:0]       in_A,
  output logic [31:0]       in_B,
  output logic              in_valid,
  output logic              in_acc_sign,
  output logic              finish,
  output logic [31:0]       custom_last,
  output logic              en_custom_last,
  input  logic [31:0]       result_all,
  input  logic              sendable,
  output logic [31:0]       res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            accept;
  logic            step;
  logic            req_pad, req_acc, req_last, real_last;
  logic            s1_valid, s1_pad, s1_acc, s1_last;

  assign accept    = (state == S_IDLE) && cmd_valid && (cmd_len != '0);
  assign step      = (state == S_ISSUE) || (state == S_PAD);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  fp_dot_beat_gen #(
    .LEN_W (LEN_W),
    .LANES (LANES)
  ) u_beat_gen (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (accept),
    .step      (step),
    .len       (cmd_len),
    .req_pad   (req_pad),
    .req_acc   (req_acc),
    .req_last  (req_last),
    .real_last (real_last)
  );

  // Stage 1 carries beat tags while the RAM returns data; stage 2 is the output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid    <= 1'b0;
      s1_pad      <= 1'b0;
      s1_acc      <= 1'b0;
      s1_last     <= 1'b0;
      in_valid    <= 1'b0;
      in_A        <= FP32_ZERO;
      in_B        <= FP32_ZERO;
      in_acc_sign <= 1'b0;
      finish      <= 1'b0;
    end else begin
      s1_valid    <= step;
      s1_pad      <= req_pad;
      s1_acc      <= req_acc;
      s1_last     <= step && req_last;
      in_valid    <= s1_valid;
      in_A        <= (s1_valid && !s1_pad) ? ram_a_data : FP32_ZERO;
      in_B        <= (s1_valid && !s1_pad) ? ram_b_data : FP32_ZERO;
      in_acc_sign <= s1_valid && s1_acc;
      finish      <= s1_valid && s1_last;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= S_IDLE;
      to_cnt         <= '0;
      ram_a_addr     <= '0;
      ram_b_addr     <= '0;
      ram_rd_en      <= 1'b0;
      custom_last    <= FP32_ZERO;
      en_custom_last <= 1'b0;
      res_data       <= '0;
      res_valid      <= 1'b0;
      err            <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && (cmd_len == '0)) begin
            err <= 1'b1;
          end else if (accept) begin
            ram_a_addr     <= cmd_base_a;
            ram_b_addr     <= cmd_base_b;
            ram_rd_en      <= 1'b1;
            custom_last    <= cmd_bias_en ? cmd_bias : FP32_ZERO;
            en_custom_last <= cmd_bias_en;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (real_last) begin
            ram_rd_en <= 1'b0;
            state     <= req_last ? S_DRAIN : S_PAD;
          end else begin
            ram_a_addr <= ram_a_addr + ADDR_W'(1);
            ram_b_addr <= ram_b_addr + ADDR_W'(1);
          end
        end
        S_PAD: begin
          if (req_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (finish) begin
            to_cnt <= '0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sendable) begin
            res_data  <= result_all;
            res_valid <= 1'b1;
            state     <= S_OUT;
          end else if (to_cnt == TO_MAX) begin
            err            <= 1'b1;
            custom_last    <= FP32_ZERO;
            en_custom_last <= 1'b0;
            state          <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid      <= 1'b0;
            custom_last    <= FP32_ZERO;
            en_custom_last <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_dot_feeder.sv
// Randomized bench for fp_dot_feeder: a RAM model plus a beat-list reference built from
// the padding/grouping rules, checked cycle by cycle on the falling edge.
module tb_fp_dot_feeder;

  localparam int ADDR_W  = 10;
  localparam int LEN_W   = 16;
  localparam int LANES   = 8;
  localparam int TIMEOUT = 32;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base_a = '0;
  logic [ADDR_W-1:0] cmd_base_b = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [31:0]       cmd_bias = '0;
  logic              cmd_bias_en = 1'b0;
  logic [ADDR_W-1:0] ram_a_addr, ram_b_addr;
  logic              ram_rd_en;
  logic [31:0]       ram_a_data = '0;
  logic [31:0]       ram_b_data = '0;
  logic [31:0]       in_A, in_B;
  logic              in_valid, in_acc_sign, finish;
  logic [31:0]       custom_last;
  logic              en_custom_last;
  logic [31:0]       result_all = '0;
  logic              sendable = 1'b0;
  logic [31:0]       res_data;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic              busy, err;

  logic [31:0] mem_a [0:(1<<ADDR_W)-1];
  logic [31:0] mem_b [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  fp_dot_feeder #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .LANES   (LANES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .aclk           (clk),
    .aresetn        (aresetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_base_a     (cmd_base_a),
    .cmd_base_b     (cmd_base_b),
    .cmd_len        (cmd_len),
    .cmd_bias       (cmd_bias),
    .cmd_bias_en    (cmd_bias_en),
    .ram_a_addr     (ram_a_addr),
    .ram_b_addr     (ram_b_addr),
    .ram_rd_en      (ram_rd_en),
    .ram_a_data     (ram_a_data),
    .ram_b_data     (ram_b_data),
    .in_A           (in_A),
    .in_B           (in_B),
    .in_valid       (in_valid),
    .in_acc_sign    (in_acc_sign),
    .finish         (finish),
    .custom_last    (custom_last),
    .en_custom_last (en_custom_last),
    .result_all     (result_all),
    .sendable       (sendable),
    .res_data       (res_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  // One-cycle-latency operand RAMs.
  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_a_data <= mem_a[ram_a_addr];
      ram_b_data <= mem_b[ram_b_addr];
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: beat k of a vector is the k-th pair (or zero once past len); groups of LANES.
  function automatic logic [65:0] exp_beat(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb,
                                           input int len, input int total, input int k);
    logic [31:0] a, b;
    logic [ADDR_W-1:0] ia, ib;
    ia = ba + ADDR_W'(k);
    ib = bb + ADDR_W'(k);
    a = (k < len) ? mem_a[ia] : 32'h0;
    b = (k < len) ? mem_b[ib] : 32'h0;
    return {a, b, (k >= LANES), (k == total - 1)};
  endfunction

  // mode 0: normal result, 1: sendable never arrives, 2: res_ready held off 5 cycles
  task automatic do_txn(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb, input int len,
                        input logic [31:0] bias, input logic ben, input logic [31:0] res, input int mode);
    int total, beat, first_cyc, fin_cyc, rd_cnt, err_cyc, d;
    logic [65:0] obs;
    total = ((len + LANES - 1) / LANES) * LANES;
    beat = 0; first_cyc = -1; fin_cyc = -1; rd_cnt = 0; err_cyc = -1;
    res_ready = (mode != 2);
    @(negedge clk);
    check("idle_ready", cmd_ready, 1'b1);
    cmd_base_a = ba; cmd_base_b = bb; cmd_len = LEN_W'(len);
    cmd_bias = bias; cmd_bias_en = ben; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc <= total + 2; cyc++) begin
      if (ram_rd_en) rd_cnt++;
      if (in_valid) begin
        obs = {in_A, in_B, in_acc_sign, finish};
        if (beat < total) check($sformatf("beat%0d", beat), obs, exp_beat(ba, bb, len, total, beat));
        if (beat == 0) first_cyc = cyc;
        beat++;
      end
      if (finish) fin_cyc = cyc;
      if (cyc == 3) begin
        check("busy", busy, 1'b1);
        check("bias", {en_custom_last, custom_last}, {ben, ben ? bias : 32'h0});
        sendable = 1'b1;
        result_all = ~res;
      end
      if (cyc == 4) sendable = 1'b0;
      @(negedge clk);
    end
    check("beat_count", beat, total);
    check("first_beat_cycle", first_cyc, 2);
    check("finish_cycle", fin_cyc, total + 1);
    check("read_count", rd_cnt, len);
    if (mode == 1) begin
      for (int n = total + 3; n <= total + 3 + TIMEOUT + 10; n++) begin
        if (err) begin
          err_cyc = n;
          break;
        end
        @(negedge clk);
      end
      check("timeout_cycle", err_cyc, total + 2 + TIMEOUT);
      check("timeout_state", {res_valid, cmd_ready, en_custom_last}, 3'b010);
      @(negedge clk);
      check("err_pulse_width", err, 1'b0);
    end else begin
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      sendable = 1'b1;
      result_all = res;
      @(negedge clk);
      sendable = 1'b0;
      result_all = $urandom;
      if (mode == 2) begin
        cmd_len = 16'd4;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
          check("hold_valid_data", {res_valid, res_data}, {1'b1, res});
          check("hold_no_accept", {cmd_ready, ram_rd_en}, 2'b00);
          @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
      end else begin
        check("res", {res_valid, res_data}, {1'b1, res});
        @(negedge clk);
      end
      check("res_done", {res_valid, cmd_ready}, 2'b01);
    end
    $display("txn base_a=%0d base_b=%0d len=%0d mode=%0d beats=%0d", ba, bb, len, mode, beat);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    for (int k = 0; k < 8; k++) begin
      mem_a[100 + k] = 32'h3F80_0000;
      mem_b[300 + k] = 32'h4000_0000;
    end
    #12;
    check("reset_ctrl", {cmd_ready, busy, err, ram_rd_en, in_valid, finish, in_acc_sign, res_valid, en_custom_last},
          9'b100000000);
    check("reset_data", {in_A, in_B, res_data, custom_last}, 128'h0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);

    do_txn(10'd100, 10'd300, 8, 32'h0, 1'b0, 32'h4180_0000, 0);
    do_txn(10'($urandom), 10'($urandom), 10, 32'h3F00_0000, 1'b1, $urandom, 0);

    @(negedge clk);
    cmd_len = '0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("len0_err", {err, cmd_ready, ram_rd_en}, 3'b110);
    @(negedge clk);
    check("len0_after", {err, busy, ram_rd_en}, 3'b000);
    $display("txn len=0 rejected");

    for (int t = 0; t < 6; t++)
      do_txn(10'($urandom), 10'($urandom), $urandom_range(1, 20), $urandom, 1'($urandom), $urandom, 0);
    do_txn(10'($urandom), 10'($urandom), 3, 32'h0, 1'b0, 32'h0, 1);
    do_txn(10'($urandom), 10'($urandom), 5, $urandom, 1'b1, $urandom, 2);
    do_txn(10'd1020, 10'd1019, 9, 32'h0, 1'b0, $urandom, 0);

    // Reset while the third beat is on the bus, then a clean short command.
    @(negedge clk);
    cmd_base_a = 10'd0; cmd_base_b = 10'd500; cmd_len = 16'd8; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 20 && seen < 3; n++) begin
      @(negedge clk);
      if (in_valid) seen++;
    end
    check("reset_beats_seen", seen, 3);
    #2 aresetn = 1'b0;
    #1;
    check("midreset_ctrl", {cmd_ready, busy, err, ram_rd_en, in_valid, finish, in_acc_sign, res_valid, en_custom_last},
          9'b100000000);
    check("midreset_data", {in_A, in_B, res_data, custom_last}, 128'h0);
    $display("txn async reset mid-issue");
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    do_txn(10'($urandom), 10'($urandom), 4, 32'h4000_0000, 1'b1, $urandom, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
